half_adder: RTL and testbench

Parameterised N-bit bitwise half adder with a registered output stage. Each bit position i independently produces sum[i] = a[i] XOR b[i] and carry[i] = a[i] AND b[i]. There is no carry propagation between bits. The block is a leaf datapath primitive: a valid-qualified, one-cycle-latency stage that larger adders and parity/compare logic instantiate.

---
 rtl/half_adder_pkg.sv | 33 +++
 rtl/half_adder_cell.sv | 14 +
 rtl/half_adder.sv | 72 +++++++
 tb/tb_half_adder.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/half_adder_pkg.sv
// rtl/half_adder_pkg.sv - shared constants and result checker for the bitwise half adder
package half_adder_pkg;

   localparam int HA_DEFAULT_WIDTH = 4;

   // Widest operand the checker accepts; narrower operands are zero-extended.
   localparam int HA_CHECK_WIDTH = 64;

   typedef logic [HA_CHECK_WIDTH-1:0] ha_word_t;

   // Returns 1 when (sum, carry) is a consistent half-add of (a, b):
   // no bit is both sum and carry, every bit pair adds up, and the
   // whole-word identity {carry,0} + sum == a + b holds.
   function automatic logic ha_check(input ha_word_t a,
                                     input ha_word_t b,
                                     input ha_word_t sum,
                                     input ha_word_t carry);
      logic                  ok;
      logic [HA_CHECK_WIDTH:0] lhs;
      logic [HA_CHECK_WIDTH:0] rhs;
      ok = ((sum & carry) == '0);
      for (int i = 0; i < HA_CHECK_WIDTH; i++) begin
         if ({carry[i], sum[i]} != ({1'b0, a[i]} + {1'b0, b[i]}))
            ok = 1'b0;
      end
      lhs = {carry, 1'b0} + {1'b0, sum};
      rhs = {1'b0, a} + {1'b0, b};
      if (lhs != rhs)
         ok = 1'b0;
      return ok;
   endfunction

endpackage

// File: rtl/half_adder_cell.sv
// rtl/half_adder_cell.sv - single-bit combinational half adder cell
module half_adder_cell
   import half_adder_pkg::*;
(
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b;
   assign carry = a & b;

endmodule

// File: rtl/half_adder.sv
// rtl/half_adder.sv - N-bit bitwise half adder with one-cycle registered output
module half_adder
   import half_adder_pkg::*;
#(
   parameter int N = HA_DEFAULT_WIDTH
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] sum,
   output logic [N-1:0] carry,
   output logic         any_carry,
   output logic         out_valid
);

   logic [N-1:0] sum_c;
   logic [N-1:0] carry_c;

   // Bits are independent: one cell per position, no carry chain.
   for (genvar i = 0; i < N; i++) begin : g_cell
      half_adder_cell u_cell (
         .a     (a[i]),
         .b     (b[i]),
         .sum   (sum_c[i]),
         .carry (carry_c[i])
      );
   end

   // Result register: load only on accepted inputs so idle-cycle X on a/b never lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum       <= '0;
         carry     <= '0;
         any_carry <= 1'b0;
      end else if (in_valid) begin
         sum       <= sum_c;
         carry     <= carry_c;
         any_carry <= |carry_c;
      end
   end

   // Valid pipeline: high exactly for the cycle after each accepted input.
   always_ff @(posedge clk) begin
      if (rst)
         out_valid <= 1'b0;
      else
         out_valid <= in_valid;
   end

`ifndef SYNTHESIS
   logic rst_q;

   // Remember last cycle's reset so the post-reset check has something to key on.
   always_ff @(posedge clk) begin
      rst_q <= rst;
   end

   // Sanity checks on the registered result.
   always_ff @(posedge clk) begin
      if (out_valid)
         assert ((sum & carry) == '0)
            else $error("half_adder: sum and carry overlap (sum=%h carry=%h)", sum, carry);
      if (rst_q === 1'b1)
         assert (out_valid == 1'b0)
            else $error("half_adder: out_valid set on the cycle after reset");
   end
`endif

endmodule

// File: tb/tb_half_adder.sv
// tb/tb_half_adder.sv - directed and random self-checking bench for half_adder
module tb_half_adder;
   import half_adder_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;

   logic [3:0]  a4, b4, s4, c4;
   logic        ac4, ov4;
   logic [0:0]  a1, b1, s1, c1;
   logic        ac1, ov1;
   logic [15:0] a16, b16, s16, c16;
   logic        ac16, ov16;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   half_adder #(.N(4)) dut4 (
      .clk (clk), .rst (rst), .in_valid (in_valid),
      .a (a4), .b (b4), .sum (s4), .carry (c4),
      .any_carry (ac4), .out_valid (ov4)
   );

   half_adder #(.N(1)) dut1 (
      .clk (clk), .rst (rst), .in_valid (in_valid),
      .a (a1), .b (b1), .sum (s1), .carry (c1),
      .any_carry (ac1), .out_valid (ov1)
   );

   half_adder #(.N(16)) dut16 (
      .clk (clk), .rst (rst), .in_valid (in_valid),
      .a (a16), .b (b16), .sum (s16), .carry (c16),
      .any_carry (ac16), .out_valid (ov16)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check4(input string tag, input logic [3:0] es, input logic [3:0] ec,
                         input logic eac, input logic eov);
      check({tag, ".sum"},       64'(s4),  64'(es));
      check({tag, ".carry"},     64'(c4),  64'(ec));
      check({tag, ".any_carry"}, 64'(ac4), 64'(eac));
      check({tag, ".out_valid"}, 64'(ov4), 64'(eov));
   endtask

   initial begin
      logic [4:0]  e4;
      logic [1:0]  e1;
      logic [16:0] e16;

      // Reset held with live inputs: nothing may be captured.
      rst = 1'b1; in_valid = 1'b1;
      a4 = 4'hF; b4 = 4'hF; a1 = 1'b1; b1 = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF;
      tick();
      check4("reset0", 4'h0, 4'h0, 1'b0, 1'b0);
      tick();
      check4("reset1", 4'h0, 4'h0, 1'b0, 1'b0);
      check("reset1.ov1",  64'(ov1),  64'd0);
      check("reset1.s16",  64'(s16),  64'd0);

      // First valid right after release, then back-to-back vectors.
      rst = 1'b0;
      a4 = 4'b1010; b4 = 4'b0110;
      tick();
      check4("basic", 4'b1100, 4'b0010, 1'b1, 1'b1);

      a4 = 4'hF; b4 = 4'hF;
      tick();
      check4("all_ones", 4'h0, 4'hF, 1'b1, 1'b1);

      a4 = 4'h0; b4 = 4'h0;
      tick();
      check4("all_zero", 4'h0, 4'h0, 1'b0, 1'b1);

      a4 = 4'h5; b4 = 4'h3;
      tick();
      check4("hold_load", 4'h6, 4'h1, 1'b1, 1'b1);

      // Idle with X operands: result holds, valid drops.
      in_valid = 1'b0; a4 = 'x; b4 = 'x;
      tick();
      check4("hold_x0", 4'h6, 4'h1, 1'b1, 1'b0);
      tick();
      check4("hold_x1", 4'h6, 4'h1, 1'b1, 1'b0);

      // Reset on the same edge as a valid input wins.
      in_valid = 1'b1; a4 = 4'h5; b4 = 4'h3;
      tick();
      check4("pre_rst", 4'h6, 4'h1, 1'b1, 1'b1);
      rst = 1'b1; a4 = 4'hC; b4 = 4'hA;
      tick();
      check4("mid_rst", 4'h0, 4'h0, 1'b0, 1'b0);
      rst = 1'b0; in_valid = 1'b0;
      tick();
      check4("post_rst", 4'h0, 4'h0, 1'b0, 1'b0);

      in_valid = 1'b1; a4 = 4'h3; b4 = 4'h1;
      tick();
      check4("after_rst", 4'h2, 4'h1, 1'b1, 1'b1);

      // Random back-to-back traffic on all three widths.
      for (int i = 0; i < 20; i++) begin
         a4 = 4'($urandom); b4 = 4'($urandom);
         a1 = 1'($urandom); b1 = 1'($urandom);
         a16 = 16'($urandom); b16 = 16'($urandom);
         tick();
         check4("rnd4", a4 ^ b4, a4 & b4, |(a4 & b4), 1'b1);
         check("rnd4.ha_check", 64'(ha_check(64'(a4), 64'(b4), 64'(s4), 64'(c4))), 64'd1);
         e4 = {c4, 1'b0} + {1'b0, s4};
         check("rnd4.arith", 64'(e4), 64'({1'b0, a4} + {1'b0, b4}));

         check("rnd1.sum",   64'(s1),  64'(a1 ^ b1));
         check("rnd1.carry", 64'(c1),  64'(a1 & b1));
         check("rnd1.any",   64'(ac1), 64'(a1 & b1));
         check("rnd1.ov",    64'(ov1), 64'd1);
         check("rnd1.ha_check", 64'(ha_check(64'(a1), 64'(b1), 64'(s1), 64'(c1))), 64'd1);
         e1 = {c1, 1'b0} + {1'b0, s1};
         check("rnd1.arith", 64'(e1), 64'({1'b0, a1} + {1'b0, b1}));

         check("rnd16.sum",   64'(s16),  64'(a16 ^ b16));
         check("rnd16.carry", 64'(c16),  64'(a16 & b16));
         check("rnd16.any",   64'(ac16), 64'(|(a16 & b16)));
         check("rnd16.ov",    64'(ov16), 64'd1);
         check("rnd16.ha_check", 64'(ha_check(64'(a16), 64'(b16), 64'(s16), 64'(c16))), 64'd1);
         e16 = {c16, 1'b0} + {1'b0, s16};
         check("rnd16.arith", 64'(e16), 64'({1'b0, a16} + {1'b0, b16}));
      end

      // Final idle cycle: valid drops on every width.
      in_valid = 1'b0;
      tick();
      check("idle.ov4",  64'(ov4),  64'd0);
      check("idle.ov1",  64'(ov1),  64'd0);
      check("idle.ov16", 64'(ov16), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
